// File: rtl/reg_select_sequencer_pkg.sv
// Shared definitions for the register-select control sequencer:
// opcode and ALU codes, FSM state encoding, instruction classes
// and the packed control word handed from the decoder to the top.
package reg_select_sequencer_pkg;

   localparam int OPW  = 5;
   localparam int ALUW = 4;

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
   localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
   localparam logic [ALUW-1:0] ALU_AND = 4'd2;
   localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   // Instructions that share an execute sequence are grouped into one class.
   typedef enum logic [2:0] {
      C_RR, C_IMM, C_LDI, C_LD, C_ST, C_NOP, C_HALT, C_ILL
   } class_e;

   typedef struct packed {
      logic pc_out;
      logic pc_in;
      logic inc_pc;
      logic mar_in;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic y_in;
      logic z_in;
      logic zlow_out;
      logic c_out;
      logic read;
      logic write;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic ba_out;
      logic illegal_op;
      logic run;
      logic [ALUW-1:0] alu_op;
   } ctrl_t;

   function automatic class_e classify(input logic [OPW-1:0] op);
      class_e c;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: c = C_RR;
         OP_ADDI, OP_ANDI, OP_ORI:      c = C_IMM;
         OP_LDI:                        c = C_LDI;
         OP_LD:                         c = C_LD;
         OP_ST:                         c = C_ST;
         OP_NOP:                        c = C_NOP;
         OP_HALT:                       c = C_HALT;
         default:                       c = C_ILL;
      endcase
      return c;
   endfunction

   // Address arithmetic for ldi/ld/st is always an add.
   function automatic logic [ALUW-1:0] alu_for(input logic [OPW-1:0] op);
      logic [ALUW-1:0] a;
      case (op)
         OP_SUB:          a = ALU_SUB;
         OP_AND, OP_ANDI: a = ALU_AND;
         OP_OR, OP_ORI:   a = ALU_OR;
         default:         a = ALU_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/reg_select_sequencer_decode.sv
// Combinational state-to-control-word decoder for the sequencer.
// Every strobe is a pure function of the current step and the
// instruction class, so each step's strobe set lives in one place.
module reg_select_sequencer_decode
   import reg_select_sequencer_pkg::*;
(
   input  state_e          state,
   input  class_e          cls,
   input  logic [ALUW-1:0] alu_sel,
   output ctrl_t           ctrl
);

   // Map each step to its strobe set; everything defaults low with run high.
   always_comb begin
      ctrl        = '0;
      ctrl.run    = 1'b1;
      ctrl.alu_op = ALU_ADD;
      case (state)
         S_T0: begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
            ctrl.z_in   = 1'b1;
         end
         S_T1: begin
            ctrl.zlow_out = 1'b1;
            ctrl.pc_in    = 1'b1;
            ctrl.read     = 1'b1;
            ctrl.mdr_in   = 1'b1;
         end
         S_T2: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_RR, C_IMM: begin
                  ctrl.grb   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               C_LDI, C_LD, C_ST: begin
                  ctrl.grb    = 1'b1;
                  ctrl.ba_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               C_ILL:   ctrl.illegal_op = 1'b1;
               default: ;
            endcase
         end
         S_T4: begin
            ctrl.z_in   = 1'b1;
            ctrl.alu_op = alu_sel;
            if (cls == C_RR) begin
               ctrl.grc   = 1'b1;
               ctrl.r_out = 1'b1;
            end else begin
               ctrl.c_out = 1'b1;
            end
         end
         S_T5: begin
            ctrl.zlow_out = 1'b1;
            if (cls == C_LD || cls == C_ST) begin
               ctrl.mar_in = 1'b1;
            end else begin
               ctrl.gra  = 1'b1;
               ctrl.r_in = 1'b1;
            end
         end
         S_T6: begin
            ctrl.mdr_in = 1'b1;
            if (cls == C_LD) begin
               ctrl.read = 1'b1;
            end else begin
               ctrl.gra   = 1'b1;
               ctrl.r_out = 1'b1;
            end
         end
         S_T7: begin
            if (cls == C_LD) begin
               ctrl.mdr_out = 1'b1;
               ctrl.gra     = 1'b1;
               ctrl.r_in    = 1'b1;
            end else begin
               ctrl.write = 1'b1;
            end
         end
         S_HALT:  ctrl.run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: rtl/reg_select_sequencer.sv
// Control sequencer for the register select/encode interface.
// Holds the step register plus the instruction class and ALU function
// captured in T3; strobes come from the decoder sub-module.
module reg_select_sequencer
   import reg_select_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic [31:0]     ir,
   input  logic            mem_ready,
   input  logic            stop,
   output logic            PCout,
   output logic            PCin,
   output logic            IncPC,
   output logic            MARin,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Yin,
   output logic            Zin,
   output logic            Zlowout,
   output logic            Cout,
   output logic            Read,
   output logic            Write,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Rin,
   output logic            Rout,
   output logic            BAout,
   output logic [ALUW-1:0] alu_op,
   output logic            run,
   output logic            illegal_op
);

   state_e          state;
   class_e          cls_q;
   logic [ALUW-1:0] alu_q;
   class_e          ir_cls;
   class_e          cur_cls;
   state_e          done_state;
   ctrl_t           ctrl;
   logic            ir_unused;

   // Only the opcode field matters to sequencing; operand fields go to the datapath.
   assign ir_unused = ^ir[31-OPW:0];

   // The IR register is loaded at the end of T2, so T3 is the first step
   // that can see the new opcode; later steps use the copy captured in T3
   // so that IR changes after T3 cannot bend the path.
   assign ir_cls     = classify(ir[31:32-OPW]);
   assign cur_cls    = (state == S_T3) ? ir_cls : cls_q;
   assign done_state = stop ? S_HALT : S_T0;

   // Step register and next-step selection; stop only counts on the last step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_RESET;
         cls_q <= C_NOP;
         alu_q <= ALU_ADD;
      end else begin
         case (state)
            S_RESET: state <= S_T0;
            S_T0:    state <= S_T1;
            S_T1:    if (mem_ready) state <= S_T2;
            S_T2:    state <= S_T3;
            S_T3: begin
               cls_q <= ir_cls;
               alu_q <= alu_for(ir[31:32-OPW]);
               case (ir_cls)
                  C_NOP, C_ILL: state <= done_state;
                  C_HALT:       state <= S_HALT;
                  default:      state <= S_T4;
               endcase
            end
            S_T4:    state <= S_T5;
            S_T5: begin
               if (cls_q == C_LD || cls_q == C_ST) state <= S_T6;
               else                                state <= done_state;
            end
            S_T6:    if (cls_q == C_ST || mem_ready) state <= S_T7;
            S_T7:    if (cls_q == C_LD || mem_ready) state <= done_state;
            S_HALT:  state <= S_HALT;
            default: state <= S_RESET;
         endcase
      end
   end

   reg_select_sequencer_decode u_decode (
      .state   (state),
      .cls     (cur_cls),
      .alu_sel (alu_q),
      .ctrl    (ctrl)
   );

   assign PCout      = ctrl.pc_out;
   assign PCin       = ctrl.pc_in;
   assign IncPC      = ctrl.inc_pc;
   assign MARin      = ctrl.mar_in;
   assign MDRin      = ctrl.mdr_in;
   assign MDRout     = ctrl.mdr_out;
   assign IRin       = ctrl.ir_in;
   assign Yin        = ctrl.y_in;
   assign Zin        = ctrl.z_in;
   assign Zlowout    = ctrl.zlow_out;
   assign Cout       = ctrl.c_out;
   assign Read       = ctrl.read;
   assign Write      = ctrl.write;
   assign Gra        = ctrl.gra;
   assign Grb        = ctrl.grb;
   assign Grc        = ctrl.grc;
   assign Rin        = ctrl.r_in;
   assign Rout       = ctrl.r_out;
   assign BAout      = ctrl.ba_out;
   assign alu_op     = ctrl.alu_op;
   assign run        = ctrl.run;
   assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Testbench for reg_select_sequencer: builds the expected per-cycle
// strobe trace of each instruction from its step table and memory
// wait lengths, then plays it against the sequencer cycle by cycle.
module tb_reg_select_sequencer;
   import reg_select_sequencer_pkg::ALU_ADD;
   import reg_select_sequencer_pkg::ALU_SUB;
   import reg_select_sequencer_pkg::ALU_AND;
   import reg_select_sequencer_pkg::ALU_OR;

   localparam logic [20:0] M_PCOUT = 21'h1 << 20;
   localparam logic [20:0] M_PCIN  = 21'h1 << 19;
   localparam logic [20:0] M_INCPC = 21'h1 << 18;
   localparam logic [20:0] M_MARIN = 21'h1 << 17;
   localparam logic [20:0] M_MDRIN = 21'h1 << 16;
   localparam logic [20:0] M_MDROUT= 21'h1 << 15;
   localparam logic [20:0] M_IRIN  = 21'h1 << 14;
   localparam logic [20:0] M_YIN   = 21'h1 << 13;
   localparam logic [20:0] M_ZIN   = 21'h1 << 12;
   localparam logic [20:0] M_ZLOW  = 21'h1 << 11;
   localparam logic [20:0] M_COUT  = 21'h1 << 10;
   localparam logic [20:0] M_READ  = 21'h1 << 9;
   localparam logic [20:0] M_WRITE = 21'h1 << 8;
   localparam logic [20:0] M_GRA   = 21'h1 << 7;
   localparam logic [20:0] M_GRB   = 21'h1 << 6;
   localparam logic [20:0] M_GRC   = 21'h1 << 5;
   localparam logic [20:0] M_RIN   = 21'h1 << 4;
   localparam logic [20:0] M_ROUT  = 21'h1 << 3;
   localparam logic [20:0] M_BAOUT = 21'h1 << 2;
   localparam logic [20:0] M_ILL   = 21'h1 << 1;
   localparam logic [20:0] M_RUN   = 21'h1;

   localparam logic [20:0] FETCH0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
   localparam logic [20:0] FETCH1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
   localparam logic [20:0] FETCH2 = M_MDROUT | M_IRIN;

   localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
   localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
   localparam logic [4:0] ADDI = 5'b01100, ANDI = 5'b01101, ORI = 5'b01110;
   localparam logic [4:0] NOP = 5'b11010, HALT = 5'b11011;

   typedef struct {
      logic [20:0] mask;
      logic [3:0]  alu;
      bit          chk_alu;
      logic        mr;
      logic        stp;
      logic [31:0] irv;
   } step_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ir = '0;
   logic        mem_ready = 1'b0;
   logic        stop = 1'b0;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
   logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal_op;
   logic [3:0]  alu_op;
   logic [20:0] obs;

   step_t exp_q[$];
   int    t6_mark;
   int    total = 0;
   int    bad = 0;

   reg_select_sequencer dut (
      .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready), .stop(stop),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
      .Cout(Cout), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .run(run),
      .illegal_op(illegal_op)
   );

   always #5 clock = ~clock;

   assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                 Cout, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, illegal_op, run};

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic step_t mk(input logic [20:0] m, input logic mr, input logic stp,
                                input logic [31:0] irv);
      step_t s;
      s.mask    = m | M_RUN;
      s.alu     = ALU_ADD;
      s.chk_alu = 1'b0;
      s.mr      = mr;
      s.stp     = stp;
      s.irv     = irv;
      return s;
   endfunction

   // Appends one instruction's expected trace: fetch, then the execute steps
   // for its opcode, stretching the memory steps by the requested waits.
   task automatic add_instr(input logic [31:0] instr, input int d1, input int dex,
                            input bit stop_end);
      logic [4:0]  op;
      logic [20:0] ex[$];
      logic [3:0]  alu;
      int          wait_k;
      int          alu_k;
      step_t       s;
      logic        stp;
      logic [31:0] irv;
      op     = instr[31:27];
      wait_k = -1;
      alu_k  = -1;
      exp_q.push_back(mk(FETCH0, rbit(), rbit(), instr));
      repeat (d1) exp_q.push_back(mk(FETCH1, 1'b0, rbit(), instr));
      exp_q.push_back(mk(FETCH1, 1'b1, rbit(), instr));
      exp_q.push_back(mk(FETCH2, rbit(), rbit(), instr));
      case (op)
         ADD, SUB, AND_, OR_: begin
            ex = '{M_GRB | M_ROUT | M_YIN, M_GRC | M_ROUT | M_ZIN, M_ZLOW | M_GRA | M_RIN};
            alu_k = 1;
         end
         ADDI, ANDI, ORI, LDI: begin
            ex = '{M_GRB | ((op == LDI) ? M_BAOUT : M_ROUT) | M_YIN, M_COUT | M_ZIN,
                   M_ZLOW | M_GRA | M_RIN};
            alu_k = 1;
         end
         LD: begin
            ex = '{M_GRB | M_BAOUT | M_YIN, M_COUT | M_ZIN, M_ZLOW | M_MARIN,
                   M_READ | M_MDRIN, M_MDROUT | M_GRA | M_RIN};
            alu_k = 1;
            wait_k = 3;
         end
         ST: begin
            ex = '{M_GRB | M_BAOUT | M_YIN, M_COUT | M_ZIN, M_ZLOW | M_MARIN,
                   M_GRA | M_ROUT | M_MDRIN, M_WRITE};
            alu_k = 1;
            wait_k = 4;
         end
         NOP, HALT: ex = '{21'h0};
         default:   ex = '{M_ILL};
      endcase
      case (op)
         SUB:        alu = ALU_SUB;
         AND_, ANDI: alu = ALU_AND;
         OR_, ORI:   alu = ALU_OR;
         default:    alu = ALU_ADD;
      endcase
      for (int k = 0; k < ex.size(); k++) begin
         stp = (k == ex.size() - 1) ? stop_end : rbit();
         irv = (k == 0) ? instr : $urandom();
         if (k == wait_k) begin
            if (op == LD) t6_mark = exp_q.size();
            repeat (dex) exp_q.push_back(mk(ex[k], 1'b0, rbit(), irv));
            exp_q.push_back(mk(ex[k], 1'b1, stp, irv));
         end else begin
            s = mk(ex[k], rbit(), stp, irv);
            s.alu = alu;
            s.chk_alu = (k == alu_k);
            exp_q.push_back(s);
         end
      end
   endtask

   // Halted cycles: every strobe low including run, inputs arbitrary.
   task automatic add_halt(input int n);
      step_t s;
      repeat (n) begin
         s = mk(21'h0, rbit(), rbit(), $urandom());
         s.mask = 21'h0;
         exp_q.push_back(s);
      end
   endtask

   task automatic drive_step(input step_t s);
      @(negedge clock);
      mem_ready = s.mr;
      stop      = s.stp;
      ir        = s.irv;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      mem_ready = 1'b0;
      stop = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         #1;
         total++;
         if (obs !== M_RUN) begin
            bad++;
            $display("[TB] FAIL reset_cycle%0d strobes=%b want=%b", i, obs, M_RUN);
         end
      end
      reset = 1'b0;
      @(negedge clock);
      #1;
      total++;
      if (obs !== (FETCH0 | M_RUN)) begin
         bad++;
         $display("[TB] FAIL reset_release strobes=%b want=%b", obs, FETCH0 | M_RUN);
      end
   endtask

   task automatic test_add();
      do_reset();
      add_instr(32'h18913000, 0, 0, 1'b0);
      exp_q.push_back(mk(FETCH0, 1'b1, 1'b0, $urandom()));
      foreach (exp_q[i]) begin
         drive_step(exp_q[i]);
         total++;
         if (obs !== exp_q[i].mask) begin
            bad++;
            $display("[TB] FAIL add_step%0d strobes=%b want=%b", i, obs, exp_q[i].mask);
         end
         if (exp_q[i].chk_alu) begin
            total++;
            if (alu_op !== exp_q[i].alu) begin
               bad++;
               $display("[TB] FAIL add_alu alu_op=%0d want=%0d", alu_op, exp_q[i].alu);
            end
         end
      end
   endtask

   task automatic test_ld();
      int reads = 0;
      do_reset();
      add_instr(32'h02280010, 3, 3, 1'b0);
      exp_q.push_back(mk(FETCH0, 1'b0, 1'b0, $urandom()));
      foreach (exp_q[i]) begin
         drive_step(exp_q[i]);
         reads += int'(Read);
         total++;
         if (obs !== exp_q[i].mask) begin
            bad++;
            $display("[TB] FAIL ld_step%0d strobes=%b want=%b", i, obs, exp_q[i].mask);
         end
      end
      total++;
      if (reads !== 8) begin
         bad++;
         $display("[TB] FAIL ld_read_cycles got=%0d want=8", reads);
      end
   endtask

   task automatic test_st();
      int writes = 0;
      int rins = 0;
      do_reset();
      add_instr({ST, 4'd3, 4'd6, 19'h20}, 1, 5, 1'b0);
      exp_q.push_back(mk(FETCH0, 1'b1, 1'b0, $urandom()));
      foreach (exp_q[i]) begin
         drive_step(exp_q[i]);
         writes += int'(Write);
         rins += int'(Rin);
         total++;
         if (obs !== exp_q[i].mask) begin
            bad++;
            $display("[TB] FAIL st_step%0d strobes=%b want=%b", i, obs, exp_q[i].mask);
         end
      end
      total += 2;
      if (writes !== 6) begin
         bad++;
         $display("[TB] FAIL st_write_cycles got=%0d want=6", writes);
      end
      if (rins !== 0) begin
         bad++;
         $display("[TB] FAIL st_rin_cycles got=%0d want=0", rins);
      end
   endtask

   task automatic test_illegal_and_halt();
      int pulses = 0;
      do_reset();
      add_instr({5'b11111, 27'($urandom())}, 0, 0, 1'b0);
      add_instr({HALT, 27'($urandom())}, 2, 0, 1'b0);
      add_halt(20);
      foreach (exp_q[i]) begin
         drive_step(exp_q[i]);
         pulses += int'(illegal_op);
         total++;
         if (obs !== exp_q[i].mask) begin
            bad++;
            $display("[TB] FAIL illhalt_step%0d strobes=%b want=%b", i, obs, exp_q[i].mask);
         end
      end
      total++;
      if (pulses !== 1) begin
         bad++;
         $display("[TB] FAIL illegal_pulses got=%0d want=1", pulses);
      end
   endtask

   task automatic test_stop();
      do_reset();
      add_instr(32'h18913000, 0, 0, 1'b1);
      add_halt(6);
      for (int i = 0; i < exp_q.size(); i++) exp_q[i].stp = (i >= 4);
      foreach (exp_q[i]) begin
         drive_step(exp_q[i]);
         total++;
         if (obs !== exp_q[i].mask) begin
            bad++;
            $display("[TB] FAIL stop_step%0d strobes=%b want=%b", i, obs, exp_q[i].mask);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      add_instr({LD, 4'd4, 4'd5, 19'h10}, 0, 6, 1'b0);
      for (int i = 0; i <= t6_mark + 1; i++) begin
         drive_step(exp_q[i]);
         total++;
         if (obs !== exp_q[i].mask) begin
            bad++;
            $display("[TB] FAIL rstmid_step%0d strobes=%b want=%b", i, obs, exp_q[i].mask);
         end
      end
      reset = 1'b1;
      #1;
      total++;
      if (obs !== M_RUN) begin
         bad++;
         $display("[TB] FAIL rstmid_abort strobes=%b want=%b", obs, M_RUN);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #1;
      total++;
      if (obs !== (FETCH0 | M_RUN)) begin
         bad++;
         $display("[TB] FAIL rstmid_restart strobes=%b want=%b", obs, FETCH0 | M_RUN);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] ops [14] = '{LD, LDI, ST, ADD, SUB, AND_, OR_, ADDI, ANDI, ORI, NOP,
                               5'b11111, 5'b00111, 5'b10101};
      do_reset();
      for (int n = 0; n < 30; n++) begin
         add_instr({ops[$urandom_range(0, 13)], 27'($urandom())},
                   $urandom_range(0, 3), $urandom_range(0, 3), n == 29);
      end
      add_halt(4);
      foreach (exp_q[i]) begin
         drive_step(exp_q[i]);
         total++;
         if (obs !== exp_q[i].mask) begin
            bad++;
            $display("[TB] FAIL b2b_step%0d strobes=%b want=%b ir=%h", i, obs,
                     exp_q[i].mask, exp_q[i].irv);
         end
         if (exp_q[i].chk_alu) begin
            total++;
            if (alu_op !== exp_q[i].alu) begin
               bad++;
               $display("[TB] FAIL b2b_alu%0d alu_op=%0d want=%0d", i, alu_op, exp_q[i].alu);
            end
         end
      end
   endtask

   // Scenario sequence, then the one summary line.
   initial begin
      test_reset();
      test_add();
      test_ld();
      test_st();
      test_illegal_and_halt();
      test_stop();
      test_reset_mid_wait();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
